// File: rtl/mem.sv
// MEM pipeline stage: drives the data-memory req/gnt/rvalid handshake and formats load/store data.
// Optional MEM_ALIGN_CHECK_EN traps misaligned half/word accesses instead of issuing them.
module mem (
  input  logic         clk,
  input  logic         rst,
  input  logic [107:0] ex2mem_bus_i,
  output logic [69:0]  mem2wb_bus_o,
  input  logic         ctl_mem_valid_i,
  input  logic         ctl_wb_allowin_i,
  output logic         ctl_mem_over_o,
  output logic [4:0]   ctl_mem_dest_o,
  output logic         dmem_req_o,
  output logic [3:0]   dmem_we_o,
  output logic [31:0]  dmem_addr_o,
  output logic [31:0]  dmem_wdata_o,
  input  logic         dmem_gnt_i,
  input  logic         dmem_rvalid_i,
  input  logic [31:0]  dmem_rdata_i,
  output logic         mem_misalign_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;

  logic [5:0]  mem_ctl;
  logic [31:0] st_data;
  logic [31:0] exe_result;
  logic [4:0]  rd_addr;
  logic        rd_we;
  logic [31:0] pc;

  assign {mem_ctl, st_data, exe_result, rd_addr, rd_we, pc} = ex2mem_bus_i;

  logic       is_load;
  logic       is_store;
  logic       is_mem;
  logic [1:0] size;
  logic       zero_ext;
  logic [1:0] lane;
  logic       unused_ctl_bit;

  // Load and store set together is treated as an ordinary ALU result.
  assign is_load        = mem_ctl[5] & ~mem_ctl[4];
  assign is_store       = mem_ctl[4] & ~mem_ctl[5];
  assign is_mem         = is_load | is_store;
  assign size           = mem_ctl[3:2];
  assign zero_ext       = mem_ctl[1];
  assign lane           = exe_result[1:0];
  assign unused_ctl_bit = mem_ctl[0];

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [31:0] result_r;
  logic        misalign_r;
  logic        flushed_r;
  logic        misaligned;

`ifdef MEM_ALIGN_CHECK_EN
  always_comb begin
    misaligned = 1'b0;
    if (size == SIZE_HALF)
      misaligned = lane[0];
    else if (size != SIZE_BYTE)
      misaligned = (lane != 2'b00);
  end
`else
  assign misaligned = 1'b0;
`endif

  logic [3:0]  st_be;
  logic [31:0] st_wdata;

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = st_data;
    case (size)
      SIZE_BYTE: begin
        st_be    = 4'b0001 << lane;
        st_wdata = {4{st_data[7:0]}};
      end
      SIZE_HALF: begin
        st_be    = 4'b0011 << lane;
        st_wdata = {2{st_data[15:0]}};
      end
      default: ;
    endcase
  end

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  always_comb begin
    ld_byte = dmem_rdata_i[7:0];
    case (lane)
      2'd1:    ld_byte = dmem_rdata_i[15:8];
      2'd2:    ld_byte = dmem_rdata_i[23:16];
      2'd3:    ld_byte = dmem_rdata_i[31:24];
      default: ld_byte = dmem_rdata_i[7:0];
    endcase
    ld_half = lane[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    ld_data = dmem_rdata_i;
    case (size)
      SIZE_BYTE: ld_data = zero_ext ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      SIZE_HALF: ld_data = zero_ext ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default:   ld_data = dmem_rdata_i;
    endcase
  end

  // A dropped valid flushes the op; after a grant the read still has to drain before IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (ctl_mem_valid_i && is_mem)
          state_nxt = misaligned ? DONE : REQ;
      end
      REQ: begin
        if (!ctl_mem_valid_i)
          state_nxt = IDLE;
        else if (dmem_gnt_i)
          state_nxt = is_store ? DONE : WAIT;
      end
      WAIT: begin
        if (dmem_rvalid_i)
          state_nxt = (ctl_mem_valid_i && !flushed_r) ? DONE : IDLE;
      end
      DONE: begin
        if (!ctl_mem_valid_i || ctl_wb_allowin_i)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      result_r   <= 32'b0;
      misalign_r <= 1'b0;
      flushed_r  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          flushed_r <= 1'b0;
          if (ctl_mem_valid_i && is_mem && misaligned) begin
            misalign_r <= 1'b1;
            result_r   <= exe_result;
          end
        end
        WAIT: begin
          if (!ctl_mem_valid_i)
            flushed_r <= 1'b1;
          if (dmem_rvalid_i)
            result_r <= ld_data;
        end
        DONE: begin
          if (state_nxt == IDLE)
            misalign_r <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign dmem_req_o   = (state == REQ) && ctl_mem_valid_i;
  assign dmem_we_o    = (dmem_req_o && is_store) ? st_be : 4'b0000;
  assign dmem_addr_o  = {exe_result[31:2], 2'b00};
  assign dmem_wdata_o = st_wdata;

  // Reset gates the combinational ALU-op handshake as well as the FSM.
  always_comb begin
    ctl_mem_over_o = 1'b0;
    if (!rst) begin
      case (state)
        IDLE:    ctl_mem_over_o = ctl_mem_valid_i && !is_mem;
        DONE:    ctl_mem_over_o = 1'b1;
        default: ctl_mem_over_o = 1'b0;
      endcase
    end
  end

  logic [31:0] wb_data;

  always_comb begin
    wb_data = exe_result;
    if (state == DONE && is_load)
      wb_data = result_r;
  end

  assign mem2wb_bus_o   = {wb_data, rd_addr, rd_we & ~misalign_r, pc};
  assign ctl_mem_dest_o = rd_addr & {5{ctl_mem_valid_i}};
  assign mem_misalign_o = misalign_r;

endmodule

// File: tb/tb_mem.sv
// Scoreboard bench for the MEM stage: stimulus pushes expected WB and dmem transactions,
// a negedge monitor pops and compares them as the DUT presents them.
`timescale 1ns/1ps
module tb_mem;

  localparam int ALU   = 0;
  localparam int LOAD  = 1;
  localparam int STORE = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [107:0] ex2mem_bus_i = '0;
  logic [69:0]  mem2wb_bus_o;
  logic         ctl_mem_valid_i = 1'b0;
  logic         ctl_wb_allowin_i = 1'b1;
  logic         ctl_mem_over_o;
  logic [4:0]   ctl_mem_dest_o;
  logic         dmem_req_o;
  logic [3:0]   dmem_we_o;
  logic [31:0]  dmem_addr_o;
  logic [31:0]  dmem_wdata_o;
  logic         dmem_gnt_i = 1'b0;
  logic         dmem_rvalid_i = 1'b0;
  logic [31:0]  dmem_rdata_i = 32'hDEADBEEF;
  logic         mem_misalign_o;

  mem dut (
    .clk              (clk),
    .rst              (rst),
    .ex2mem_bus_i     (ex2mem_bus_i),
    .mem2wb_bus_o     (mem2wb_bus_o),
    .ctl_mem_valid_i  (ctl_mem_valid_i),
    .ctl_wb_allowin_i (ctl_wb_allowin_i),
    .ctl_mem_over_o   (ctl_mem_over_o),
    .ctl_mem_dest_o   (ctl_mem_dest_o),
    .dmem_req_o       (dmem_req_o),
    .dmem_we_o        (dmem_we_o),
    .dmem_addr_o      (dmem_addr_o),
    .dmem_wdata_o     (dmem_wdata_o),
    .dmem_gnt_i       (dmem_gnt_i),
    .dmem_rvalid_i    (dmem_rvalid_i),
    .dmem_rdata_i     (dmem_rdata_i),
    .mem_misalign_o   (mem_misalign_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk_wdata;
  } req_t;

  logic [69:0] wb_q[$];
  req_t        req_q[$];
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic checkOutput(input string name, input logic [69:0] act, input logic [69:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares WB handshakes and granted dmem requests against the queues.
  always @(negedge clk) begin
    if (!rst && ctl_mem_over_o && ctl_wb_allowin_i && ctl_mem_valid_i) begin
      if (wb_q.size() == 0)
        checkOutput("wb_unexpected", mem2wb_bus_o, 70'h0);
      else
        checkOutput("wb_bus", mem2wb_bus_o, wb_q.pop_front());
    end
    if (!rst && dmem_req_o && dmem_gnt_i) begin
      if (req_q.size() == 0)
        checkOutput("req_unexpected", {dmem_we_o, dmem_addr_o}, 36'h0);
      else begin
        req_t r;
        r = req_q.pop_front();
        checkOutput("req_we_addr", {dmem_we_o, dmem_addr_o}, {r.we, r.addr});
        if (r.chk_wdata)
          checkOutput("req_wdata", dmem_wdata_o, r.wdata);
      end
    end
  end

  task automatic applyStimulus(input string name, input int kind, input logic [5:0] ctl,
                               input logic [31:0] st, input logic [31:0] exe, input logic [4:0] rd,
                               input logic rdwe, input logic [31:0] pc, input logic [31:0] rdata,
                               input int gnt_delay, input int hold, input logic [31:0] exp_wb,
                               input logic [3:0] exp_be, input logic [31:0] exp_wdata);
    req_t r;
    ex2mem_bus_i     = {ctl, st, exe, rd, rdwe, pc};
    ctl_mem_valid_i  = 1'b1;
    ctl_wb_allowin_i = (hold == 0);
    wb_q.push_back({exp_wb, rd, rdwe, pc});
    if (kind == ALU) begin
      @(negedge clk);
      checkOutput({name, "_no_req"}, dmem_req_o, 1'b0);
      checkOutput({name, "_dest"}, ctl_mem_dest_o, rd);
      cyc();
      ctl_mem_valid_i = 1'b0;
      return;
    end
    r.we        = exp_be;
    r.addr      = {exe[31:2], 2'b00};
    r.wdata     = exp_wdata;
    r.chk_wdata = (kind == STORE);
    req_q.push_back(r);
    @(negedge clk);
    checkOutput({name, "_over_idle"}, ctl_mem_over_o, 1'b0);
    cyc();
    for (int i = 0; i < gnt_delay; i++) begin
      @(negedge clk);
      checkOutput({name, "_req_hold"}, {dmem_req_o, dmem_we_o, dmem_addr_o}, {1'b1, exp_be, r.addr});
      checkOutput({name, "_over_req"}, ctl_mem_over_o, 1'b0);
      cyc();
    end
    dmem_gnt_i = 1'b1;
    @(negedge clk);
    checkOutput({name, "_misalign_low"}, mem_misalign_o, 1'b0);
    cyc();
    dmem_gnt_i = 1'b0;
    if (kind == LOAD) begin
      dmem_rvalid_i = 1'b1;
      dmem_rdata_i  = rdata;
      @(negedge clk);
      checkOutput({name, "_over_wait"}, ctl_mem_over_o, 1'b0);
      cyc();
      dmem_rvalid_i = 1'b0;
      dmem_rdata_i  = 32'hDEADBEEF;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checkOutput({name, "_over_hold"}, ctl_mem_over_o, 1'b1);
      checkOutput({name, "_wb_hold"}, mem2wb_bus_o[69:38], exp_wb);
      cyc();
    end
    ctl_wb_allowin_i = 1'b1;
    @(negedge clk);
    cyc();
    ctl_mem_valid_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    req_t r;
    // Reset: an ALU op presented during reset must not raise over.
    ex2mem_bus_i    = {6'b000000, 32'h0, 32'h12345678, 5'd3, 1'b1, 32'h100};
    ctl_mem_valid_i = 1'b1;
    @(negedge clk);
    checkOutput("rst_over", ctl_mem_over_o, 1'b0);
    checkOutput("rst_req_we", {dmem_req_o, dmem_we_o}, 5'b0);
    checkOutput("rst_misalign", mem_misalign_o, 1'b0);
    cyc();
    ctl_mem_valid_i = 1'b0;
    rst = 1'b0;
    cyc();

    applyStimulus("alu", ALU, 6'b000000, 32'h0, 32'h12345678, 5'd3, 1'b1, 32'h100,
                  32'h0, 0, 0, 32'h12345678, 4'h0, 32'h0);
    applyStimulus("ld_st_both", ALU, 6'b110010, 32'hFFFF0000, 32'h00004444, 5'd4, 1'b1, 32'h104,
                  32'h0, 0, 0, 32'h00004444, 4'h0, 32'h0);
    applyStimulus("lb", LOAD, 6'b100000, 32'h0, 32'h1003, 5'd5, 1'b1, 32'h200,
                  32'h80FFFFFF, 0, 0, 32'hFFFFFF80, 4'h0, 32'h0);
    applyStimulus("lbu", LOAD, 6'b100010, 32'h0, 32'h1003, 5'd5, 1'b1, 32'h204,
                  32'h80FFFFFF, 0, 0, 32'h00000080, 4'h0, 32'h0);
    applyStimulus("sh", STORE, 6'b010100, 32'hABCD1234, 32'h2002, 5'd0, 1'b0, 32'h208,
                  32'h0, 0, 0, 32'h00002002, 4'b1100, 32'h12341234);
    applyStimulus("sb", STORE, 6'b010000, 32'h000000A5, 32'h6001, 5'd0, 1'b0, 32'h20C,
                  32'h0, 0, 0, 32'h00006001, 4'b0010, 32'hA5A5A5A5);
    applyStimulus("sw", STORE, 6'b011000, 32'h11223344, 32'h7000, 5'd0, 1'b0, 32'h210,
                  32'h0, 0, 0, 32'h00007000, 4'b1111, 32'h11223344);
    applyStimulus("lh", LOAD, 6'b100100, 32'h0, 32'h5002, 5'd6, 1'b1, 32'h214,
                  32'h80017FFF, 0, 0, 32'hFFFF8001, 4'h0, 32'h0);
    applyStimulus("lhu", LOAD, 6'b100110, 32'h0, 32'h5000, 5'd6, 1'b1, 32'h218,
                  32'h8001F234, 0, 0, 32'h0000F234, 4'h0, 32'h0);
    applyStimulus("lw_slow", LOAD, 6'b101001, 32'h0, 32'h4008, 5'd8, 1'b1, 32'h21C,
                  32'hCAFEF00D, 5, 3, 32'hCAFEF00D, 4'h0, 32'h0);

`ifdef MEM_ALIGN_CHECK_EN
    ex2mem_bus_i     = {6'b101000, 32'h0, 32'h3001, 5'd7, 1'b1, 32'h300};
    ctl_mem_valid_i  = 1'b1;
    ctl_wb_allowin_i = 1'b1;
    wb_q.push_back({32'h00003001, 5'd7, 1'b0, 32'h300});
    @(negedge clk);
    checkOutput("mis_idle", {dmem_req_o, ctl_mem_over_o}, 2'b00);
    cyc();
    @(negedge clk);
    checkOutput("mis_done", {mem_misalign_o, dmem_req_o, ctl_mem_over_o}, 3'b101);
    cyc();
    ctl_mem_valid_i = 1'b0;
    @(negedge clk);
    checkOutput("mis_clear", mem_misalign_o, 1'b0);
    cyc();
`else
    applyStimulus("lw_mis", LOAD, 6'b101000, 32'h0, 32'h3001, 5'd7, 1'b1, 32'h300,
                  32'h55AA55AA, 0, 0, 32'h55AA55AA, 4'h0, 32'h0);
`endif

    // Flush while waiting for read data.
    ex2mem_bus_i     = {6'b101000, 32'h0, 32'h8000, 5'd9, 1'b1, 32'h400};
    ctl_mem_valid_i  = 1'b1;
    r.we = 4'h0; r.addr = 32'h8000; r.wdata = 32'h0; r.chk_wdata = 1'b0;
    req_q.push_back(r);
    @(negedge clk);
    cyc();
    dmem_gnt_i = 1'b1;
    @(negedge clk);
    cyc();
    dmem_gnt_i      = 1'b0;
    ctl_mem_valid_i = 1'b0;
    @(negedge clk);
    checkOutput("flush_wait_over", ctl_mem_over_o, 1'b0);
    cyc();
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'h12345678;
    @(negedge clk);
    checkOutput("flush_rvalid_over", ctl_mem_over_o, 1'b0);
    cyc();
    dmem_rvalid_i = 1'b0;
    @(negedge clk);
    checkOutput("flush_idle_over", ctl_mem_over_o, 1'b0);
    cyc();
    applyStimulus("lb_after_flush", LOAD, 6'b100000, 32'h0, 32'h1001, 5'd10, 1'b1, 32'h404,
                  32'h00007F00, 0, 0, 32'h0000007F, 4'h0, 32'h0);

    // Flush before the grant drops the request immediately; a stray grant is ignored.
    ex2mem_bus_i    = {6'b101000, 32'h0, 32'h8100, 5'd11, 1'b1, 32'h408};
    ctl_mem_valid_i = 1'b1;
    @(negedge clk);
    cyc();
    @(negedge clk);
    checkOutput("req_before_flush", dmem_req_o, 1'b1);
    cyc();
    ctl_mem_valid_i = 1'b0;
    @(negedge clk);
    checkOutput("req_dropped", dmem_req_o, 1'b0);
    cyc();
    dmem_gnt_i = 1'b1;
    @(negedge clk);
    checkOutput("stray_gnt", {dmem_req_o, ctl_mem_over_o}, 2'b00);
    cyc();
    dmem_gnt_i = 1'b0;

    // Valid falling in DONE returns to IDLE without a handshake.
    ex2mem_bus_i     = {6'b011000, 32'h0BADF00D, 32'hA000, 5'd0, 1'b0, 32'h500};
    ctl_mem_valid_i  = 1'b1;
    ctl_wb_allowin_i = 1'b0;
    r.we = 4'b1111; r.addr = 32'hA000; r.wdata = 32'h0BADF00D; r.chk_wdata = 1'b1;
    req_q.push_back(r);
    @(negedge clk);
    cyc();
    dmem_gnt_i = 1'b1;
    @(negedge clk);
    cyc();
    dmem_gnt_i      = 1'b0;
    ctl_mem_valid_i = 1'b0;
    @(negedge clk);
    checkOutput("done_over", ctl_mem_over_o, 1'b1);
    cyc();
    @(negedge clk);
    checkOutput("done_flush_idle", ctl_mem_over_o, 1'b0);
    cyc();
    ctl_wb_allowin_i = 1'b1;

    // Asynchronous reset in WAIT abandons the load; the late rvalid is ignored.
    ex2mem_bus_i    = {6'b101000, 32'h0, 32'h9000, 5'd12, 1'b1, 32'h600};
    ctl_mem_valid_i = 1'b1;
    r.we = 4'h0; r.addr = 32'h9000; r.wdata = 32'h0; r.chk_wdata = 1'b0;
    req_q.push_back(r);
    @(negedge clk);
    cyc();
    dmem_gnt_i = 1'b1;
    @(negedge clk);
    cyc();
    dmem_gnt_i = 1'b0;
    #1 rst = 1'b1;
    #1;
    checkOutput("async_rst", {dmem_req_o, dmem_we_o, ctl_mem_over_o, mem_misalign_o}, 7'b0);
    ctl_mem_valid_i = 1'b0;
    cyc();
    rst = 1'b0;
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'hFFFFFFFF;
    @(negedge clk);
    checkOutput("late_rvalid", {dmem_req_o, ctl_mem_over_o}, 2'b00);
    cyc();
    dmem_rvalid_i = 1'b0;
    @(negedge clk);
    checkOutput("late_rvalid_idle", ctl_mem_over_o, 1'b0);
    cyc();

    checkOutput("wb_queue_empty", wb_q.size(), 0);
    checkOutput("req_queue_empty", req_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
